sum_frame_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit summation datapath between two sample requesters. It grants one requester at a time and streams a fixed-length frame from it into the accumulator, marking the first sample with a start pulse. It then waits for the accumulator's sum strobe and returns the 17-bit result, tagged with the owner ID, to the requesters. A watchdog aborts the transaction if the sum never arrives.

---
 rtl/sum_frame_scheduler.sv | 131 +++++++++++++
 tb/tb_sum_frame_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_frame_scheduler.sv
// Round-robin arbiter that streams fixed-length frames from two requesters into one
// summation datapath, then returns the owner-tagged sum or aborts on a WAIT watchdog.
module sum_frame_scheduler #(
  parameter int FRAME_LEN = 256,
  parameter int TIMEOUT   = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  acc_data,
  output logic        acc_start,
  input  logic [16:0] acc_sum,
  input  logic        acc_sum_en,
  output logic [16:0] result,
  output logic        result_id,
  output logic        result_valid,
  output logic        err,
  output logic        busy
);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_SMP  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;
  typedef struct packed {
    logic [16:0] sum;
    logic        id;
  } res_t;

  state_t        state, state_d;
  logic          owner, owner_d, last_owner, last_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [7:0]    data_d;
  logic          start_d, rv_d, err_d;
  res_t          res, res_d;

  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last_owner;
    cnt_d   = cnt;
    tcnt_d  = tcnt;
    data_d  = acc_data;
    start_d = 1'b0;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    res_d   = res;
    case (state)
      IDLE: if (req0 || req1) begin
        // on contention the requester that did not own the last transaction wins
        owner_d = (req0 && req1) ? ~last_owner : req1;
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        data_d  = owner ? data1 : data0;
        start_d = (cnt == '0);
        if (cnt == LAST_SMP) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT: begin
        // a strobe on the final watchdog cycle still counts as a result
        if (acc_sum_en) begin
          res_d   = '{sum: acc_sum, id: owner};
          rv_d    = 1'b1;
          tcnt_d  = '0;
          state_d = DONE;
        end else if (tcnt == LAST_WAIT) begin
          err_d   = 1'b1;
          last_d  = owner;
          tcnt_d  = '0;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      DONE: begin
        last_d  = owner;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      cnt          <= '0;
      tcnt         <= '0;
      acc_data     <= '0;
      acc_start    <= 1'b0;
      res          <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      owner        <= owner_d;
      last_owner   <= last_d;
      cnt          <= cnt_d;
      tcnt         <= tcnt_d;
      acc_data     <= data_d;
      acc_start    <= start_d;
      res          <= res_d;
      result_valid <= rv_d;
      err          <= err_d;
      gnt0         <= (state_d == STREAM) && !owner_d;
      gnt1         <= (state_d == STREAM) && owner_d;
      busy         <= (state_d != IDLE);
    end
  end

  assign result    = res.sum;
  assign result_id = res.id;
endmodule

// File: tb/tb_sum_frame_scheduler.sv
// Bench for sum_frame_scheduler: frame-level reference model compared every cycle,
// a summing responder standing in for the datapath, and directed plus random phases.
module tb_sum_frame_scheduler;
  localparam int FL = 256;
  localparam int TO = 16;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  data0 = '0, data1 = '0;
  logic        gnt0, gnt1, acc_start, result_id, result_valid, err, busy;
  logic [7:0]  acc_data;
  logic [16:0] result, acc_sum;
  logic        acc_sum_en;
  logic        resp_en = 1'b0, stray_en = 1'b0;
  logic [16:0] resp_sum = '0, stray_val = '0;

  assign acc_sum_en = resp_en | stray_en;
  assign acc_sum    = resp_en ? resp_sum : stray_val;

  int total = 0, bad = 0, cyc = 0;
  int resp_delay = 2, dmode = 0, didx = 0;
  bit rand_delay = 1'b0;

  sum_frame_scheduler #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .acc_data(acc_data), .acc_start(acc_start),
    .acc_sum(acc_sum), .acc_sum_en(acc_sum_en), .result(result), .result_id(result_id),
    .result_valid(result_valid), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: a frame is a countdown of samples left, then a count of waiting
  // cycles, then one completion cycle. Values hold what the outputs show after the edge.
  int          m_left = 0, m_wait = -1;
  bit          m_own = 1'b0, m_last = 1'b1, m_done = 1'b0;
  bit          m_start = 1'b0, m_rv = 1'b0, m_err = 1'b0, m_rid = 1'b0;
  logic [7:0]  m_data = '0;
  logic [16:0] m_res = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_left <= 0; m_wait <= -1; m_own <= 1'b0; m_last <= 1'b1; m_done <= 1'b0;
      m_start <= 1'b0; m_rv <= 1'b0; m_err <= 1'b0; m_rid <= 1'b0;
      m_data <= '0; m_res <= '0;
    end else begin
      m_start <= 1'b0; m_rv <= 1'b0; m_err <= 1'b0;
      if (m_left > 0) begin
        m_data  <= m_own ? data1 : data0;
        m_start <= (m_left == FL);
        m_left  <= m_left - 1;
        if (m_left == 1) m_wait <= 0;
      end else if (m_wait >= 0) begin
        if (acc_sum_en) begin
          m_res <= acc_sum; m_rid <= m_own; m_rv <= 1'b1; m_wait <= -1; m_done <= 1'b1;
        end else if (m_wait == TO - 1) begin
          m_err <= 1'b1; m_last <= m_own; m_wait <= -1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_done) begin
        m_done <= 1'b0; m_last <= m_own;
      end else if (req0 || req1) begin
        m_own  <= (req0 && req1) ? !m_last : req1;
        m_left <= FL;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("gnt0", gnt0, m_left > 0 && !m_own);
    chk("gnt1", gnt1, m_left > 0 && m_own);
    chk("gnt_overlap", gnt0 & gnt1, 0);
    chk("acc_data", acc_data, m_data);
    chk("acc_start", acc_start, m_start);
    chk("result", result, m_res);
    chk("result_id", result_id, m_rid);
    chk("result_valid", result_valid, m_rv);
    chk("err", err, m_err);
    chk("busy", busy, m_left > 0 || m_wait >= 0 || m_done);
  end

  // event log used by the directed checks
  int g_log[$], r_log[$], id_log[$];
  int n_start = 0, start_data = -1, n_rv = 0, n_err = 0;
  int t_wait = 0, t_err = 0, t_rv = 0, glen = 0, last_glen = 0;
  bit pg0 = 1'b0, pg1 = 1'b0;

  initial forever begin
    @(negedge CLK);
    if (gnt0 === 1'b1 && !pg0) g_log.push_back(0);
    if (gnt1 === 1'b1 && !pg1) g_log.push_back(1);
    if (gnt0 === 1'b1 || gnt1 === 1'b1) glen++;
    else if (pg0 || pg1) begin last_glen = glen; glen = 0; t_wait = cyc; end
    pg0 = (gnt0 === 1'b1);
    pg1 = (gnt1 === 1'b1);
    if (acc_start === 1'b1) begin n_start++; start_data = int'(acc_data); end
    if (result_valid === 1'b1) begin
      n_rv++; r_log.push_back(int'(result)); id_log.push_back(int'(result_id)); t_rv = cyc;
    end
    if (err === 1'b1) begin n_err++; t_err = cyc; end
  end

  // summation datapath stand-in: sums one frame, answers after a programmable delay
  int r_acc, r_n, r_d;
  initial forever begin
    @(negedge CLK);
    if (RST === 1'b1 && acc_start === 1'b1) begin
      r_acc = int'(acc_data);
      r_n   = 1;
      while (r_n < FL && RST === 1'b1) begin
        @(negedge CLK);
        if (RST === 1'b1) begin r_acc += int'(acc_data); r_n++; end
      end
      if (r_n == FL && RST === 1'b1) begin
        r_d = rand_delay ? int'($urandom_range(0, 20)) : resp_delay;
        if (r_d >= 0) begin
          repeat (r_d) @(posedge CLK);
          #1 resp_sum = 17'(r_acc); resp_en = 1'b1;
          @(posedge CLK);
          #1 resp_en = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    case (dmode)
      0: if (gnt0 || gnt1) begin data0 = 8'(didx); data1 = 8'(didx); didx++; end
         else didx = 0;
      1: begin data0 = 8'hFF; data1 = 8'h01; end
      default: begin data0 = 8'($urandom); data1 = 8'($urandom); end
    endcase
  end

  // kind: 0 n_rv>=target, 1 n_err>=target, 2 gnt0, 3 gnt1, 4 grants>=target, 5 idle
  task automatic wait_evt(input string what, input int kind, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if ((kind == 0 && n_rv >= target) || (kind == 1 && n_err >= target) ||
          (kind == 2 && gnt0 === 1'b1) || (kind == 3 && gnt1 === 1'b1) ||
          (kind == 4 && g_log.size() >= target) || (kind == 5 && busy === 1'b0)) return;
    end
    total++; bad++;
    $display("FAIL wait_%s: got no event want one within %0d cycles", what, budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int g0, rv0, er0, st0, rvr;
    logic [16:0] saved;
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_acc_data", acc_data, 0);
    chk("rst_result", result, 0);
    chk("rst_result_id", result_id, 0);
    RST = 1'b1;

    // contention: both held for four frames
    dmode = 1; resp_delay = 2; g0 = g_log.size(); rv0 = n_rv;
    @(posedge CLK); #1 req0 = 1'b1; req1 = 1'b1;
    wait_evt("four_grants", 4, g0 + 4, 1500);
    @(posedge CLK); #1 req0 = 1'b0; req1 = 1'b0;
    wait_evt("four_results", 0, rv0 + 4, 600);
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      chk("cont_order", (g_log.size() > g0 + i) ? g_log[g0 + i] : -1, i % 2);
      chk("cont_result", (r_log.size() > rv0 + i) ? r_log[rv0 + i] : -1, (i % 2) ? 256 : 65280);
      chk("cont_id", (id_log.size() > rv0 + i) ? id_log[rv0 + i] : -1, i % 2);
    end

    // single request with index data
    dmode = 0; resp_delay = 2; rv0 = n_rv; st0 = n_start;
    @(posedge CLK); #1 req0 = 1'b1;
    wait_evt("single_gnt0", 2, 0, 20);
    @(posedge CLK); #1 req0 = 1'b0;
    wait_evt("single_result", 0, rv0 + 1, 400);
    repeat (4) @(negedge CLK);
    chk("single_gnt_len", last_glen, FL);
    chk("single_starts", n_start, st0 + 1);
    chk("single_start_data", start_data, 0);
    chk("single_result", result, 32640);
    chk("single_id", result_id, 0);
    chk("single_rv_count", n_rv, rv0 + 1);
    chk("single_latency", t_rv - t_wait, 3);

    // timeout: no strobe
    resp_delay = -1; rv0 = n_rv; er0 = n_err; saved = result;
    @(posedge CLK); #1 req1 = 1'b1;
    wait_evt("to_gnt1", 3, 0, 20);
    @(posedge CLK); #1 req1 = 1'b0;
    wait_evt("to_err", 1, er0 + 1, 400);
    repeat (3) @(negedge CLK);
    chk("to_err_delay", t_err - t_wait, TO);
    chk("to_err_count", n_err, er0 + 1);
    chk("to_no_rv", n_rv, rv0);
    chk("to_result_held", result, saved);

    // strobe lands on the watchdog's last cycle
    resp_delay = TO - 1; rv0 = n_rv; er0 = n_err;
    @(posedge CLK); #1 req0 = 1'b1;
    wait_evt("race_gnt0", 2, 0, 20);
    @(posedge CLK); #1 req0 = 1'b0;
    wait_evt("race_result", 0, rv0 + 1, 400);
    repeat (3) @(negedge CLK);
    chk("race_no_err", n_err, er0);
    chk("race_rv_count", n_rv, rv0 + 1);
    chk("race_latency", t_rv - t_wait, TO);
    chk("race_result", result, 32640);

    // reset in the middle of a frame
    resp_delay = 2; rv0 = n_rv; er0 = n_err;
    @(posedge CLK); #1 req0 = 1'b1;
    wait_evt("mid_gnt0", 2, 0, 20);
    repeat (100) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_gnt0", gnt0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", acc_start, 0);
    req1 = 1'b1;
    repeat (3) @(negedge CLK);
    g0 = g_log.size();
    RST = 1'b1;
    wait_evt("post_rst_grant", 4, g0 + 1, 20);
    chk("post_rst_first", (g_log.size() > g0) ? g_log[g0] : -1, 0);
    chk("post_rst_no_rv", n_rv, rv0);
    chk("post_rst_no_err", n_err, er0);
    @(posedge CLK); #1 req0 = 1'b0;
    wait_evt("post_rst_gnt1", 3, 0, 600);
    @(posedge CLK); #1 req1 = 1'b0;
    wait_evt("post_rst_results", 0, rv0 + 2, 400);

    // stray strobes and an early req drop
    dmode = 1; rv0 = n_rv;
    wait_evt("stray_idle", 5, 0, 100);
    @(posedge CLK); #1 stray_val = 17'h1ABCD; stray_en = 1'b1;
    @(posedge CLK); #1 stray_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1 req1 = 1'b1;
    wait_evt("stray_gnt1", 3, 0, 20);
    repeat (10) @(posedge CLK);
    #1 stray_val = 17'h00777; stray_en = 1'b1;
    @(posedge CLK); #1 stray_en = 1'b0;
    repeat (20) @(posedge CLK);
    #1 req1 = 1'b0;
    wait_evt("stray_result", 0, rv0 + 1, 400);
    repeat (30) @(negedge CLK);
    chk("stray_gnt_len", last_glen, FL);
    chk("stray_rv_count", n_rv, rv0 + 1);
    chk("stray_result", result, 256);
    chk("stray_id", result_id, 1);

    // random traffic, data, response delays and strays
    dmode = 2; rand_delay = 1'b1; rvr = n_rv;
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK); #1;
      if (!req0 && $urandom_range(0, 7) == 0) req0 = 1'b1;
      else if (gnt0 && $urandom_range(0, 3) == 0) req0 = 1'b0;
      if (!req1 && $urandom_range(0, 7) == 0) req1 = 1'b1;
      else if (gnt1 && $urandom_range(0, 3) == 0) req1 = 1'b0;
      stray_en  = ($urandom_range(0, 63) == 0);
      stray_val = 17'($urandom);
    end
    @(posedge CLK); #1 req0 = 1'b0; req1 = 1'b0; stray_en = 1'b0;
    wait_evt("rand_idle", 5, 0, 600);
    repeat (25) @(negedge CLK);
    chk("rand_activity", n_rv > rvr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
